// File: rtl/flag_stack_reg.sv
// Condition-flag register with a small LIFO save stack.
// Live flags take masked writes every cycle; push saves them, pop restores
// them (masked-write bits still win). Over/underflow attempts raise sticky errors.

// One live flag bit: a masked write beats a restore, which beats hold.
module flag_stack_bit (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_wr_en,
  input  logic i_wr_d,
  input  logic i_pop_en,
  input  logic i_pop_d,
  output logic o_q
);
  logic r_q;

  // Flag bit register with write-over-restore priority
  always_ff @(posedge i_clk) begin
    if (i_reset)       r_q <= 1'b0;
    else if (i_wr_en)  r_q <= i_wr_d;
    else if (i_pop_en) r_q <= i_pop_d;
  end

  assign o_q = r_q;
endmodule

module flag_stack_reg #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_wr_mask,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_clr_err,
  output logic [WIDTH-1:0] o_flags,
  output logic [CW-1:0]    o_count,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_ovf_err,
  output logic             o_unf_err
);

  logic [DEPTH-1:0][WIDTH-1:0] r_stack;
  logic [CW-1:0]               r_count;
  logic                        r_ovf_err;
  logic                        r_unf_err;

  logic [WIDTH-1:0] w_flags;
  logic [WIDTH-1:0] w_top;
  logic [CW-1:0]    w_top_idx;
  logic             w_full;
  logic             w_empty;
  logic             w_push_only;
  logic             w_pop_only;
  logic             w_push_ok;
  logic             w_pop_ok;
  logic             w_ovf_evt;
  logic             w_unf_evt;

  // full/empty come straight from the registered count
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

  // push together with pop cancels out: stack untouched, no error
  assign w_push_only = i_push & ~i_pop;
  assign w_pop_only  = i_pop  & ~i_push;
  assign w_push_ok   = w_push_only & ~w_full;
  assign w_pop_ok    = w_pop_only  & ~w_empty;
  assign w_ovf_evt   = w_push_only &  w_full;
  assign w_unf_evt   = w_pop_only  &  w_empty;

  // Only meaningful when w_pop_ok, i.e. count >= 1
  assign w_top_idx = r_count - CW'(1);

  // Select the top-of-stack entry by comparing each slot index
  always_comb begin
    w_top = '0;
    for (int s = 0; s < DEPTH; s++) begin
      if (CW'(s) == w_top_idx) w_top = r_stack[s];
    end
  end

  // Per-bit live flag cells
  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    flag_stack_bit u_bit (
      .i_clk    (i_clk),
      .i_reset  (i_reset),
      .i_wr_en  (i_wr_mask[g]),
      .i_wr_d   (i_wr_data[g]),
      .i_pop_en (w_pop_ok),
      .i_pop_d  (w_top[g]),
      .o_q      (w_flags[g])
    );
  end

  // Save slots: pre-edge flags go into slot[count] on a legal push; contents
  // need no reset since count gates every read
  always_ff @(posedge i_clk) begin
    for (int s = 0; s < DEPTH; s++) begin
      if (w_push_ok && (CW'(s) == r_count)) r_stack[s] <= w_flags;
    end
  end

  // Occupancy counter, saturating by construction (only legal ops move it)
  always_ff @(posedge i_clk) begin
    if (i_reset)        r_count <= '0;
    else if (w_push_ok) r_count <= r_count + CW'(1);
    else if (w_pop_ok)  r_count <= r_count - CW'(1);
  end

  // Sticky errors; a fresh event outranks clr_err in the same cycle
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ovf_err <= 1'b0;
      r_unf_err <= 1'b0;
    end else begin
      r_ovf_err <= w_ovf_evt | (r_ovf_err & ~i_clr_err);
      r_unf_err <= w_unf_evt | (r_unf_err & ~i_clr_err);
    end
  end

  assign o_flags   = w_flags;
  assign o_count   = r_count;
  assign o_full    = w_full;
  assign o_empty   = w_empty;
  assign o_ovf_err = r_ovf_err;
  assign o_unf_err = r_unf_err;

endmodule

// File: tb/tb_flag_stack_reg.sv
// Directed vector bench for flag_stack_reg (DEPTH=4 table, DEPTH=1 sequence).
module tb_flag_stack_reg;
  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // DEPTH=4 instance
  logic       rst, push, pop, clr;
  logic [3:0] mask, data;
  logic [3:0] flags;
  logic [2:0] count;
  logic       full, empty, ovf, unf;

  flag_stack_reg #(.WIDTH(4), .DEPTH(4)) dut (
    .i_clk(clk), .i_reset(rst), .i_wr_mask(mask), .i_wr_data(data),
    .i_push(push), .i_pop(pop), .i_clr_err(clr),
    .o_flags(flags), .o_count(count), .o_full(full), .o_empty(empty),
    .o_ovf_err(ovf), .o_unf_err(unf)
  );

  // DEPTH=1 instance
  logic       rst1, push1, pop1, clr1;
  logic [3:0] mask1, data1;
  logic [3:0] flags1;
  logic [0:0] count1;
  logic       full1, empty1, ovf1, unf1;

  flag_stack_reg #(.WIDTH(4), .DEPTH(1)) dut1 (
    .i_clk(clk), .i_reset(rst1), .i_wr_mask(mask1), .i_wr_data(data1),
    .i_push(push1), .i_pop(pop1), .i_clr_err(clr1),
    .o_flags(flags1), .o_count(count1), .o_full(full1), .o_empty(empty1),
    .o_ovf_err(ovf1), .o_unf_err(unf1)
  );

  typedef struct {
    logic       rst;
    logic [3:0] mask;
    logic [3:0] data;
    logic       push;
    logic       pop;
    logic       clr;
    logic [3:0] e_flags;
    logic [2:0] e_count;
    logic       e_full;
    logic       e_empty;
    logic       e_ovf;
    logic       e_unf;
  } vec_t;

  vec_t vt[$];
  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(logic r, logic [3:0] m, logic [3:0] d, logic pu, logic po,
                              logic c, logic [3:0] ef, logic [2:0] ec, logic efl,
                              logic eem, logic eo, logic eu);
    vec_t v;
    v.rst = r; v.mask = m; v.data = d; v.push = pu; v.pop = po; v.clr = c;
    v.e_flags = ef; v.e_count = ec; v.e_full = efl; v.e_empty = eem;
    v.e_ovf = eo; v.e_unf = eu;
    return v;
  endfunction

  task automatic chk(string name, int idx, logic [3:0] act, logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %b expected %b", name, idx, act, exp);
    end
  endtask

  initial begin
    rst = 1; mask = 0; data = 0; push = 0; pop = 0; clr = 0;
    rst1 = 1; mask1 = 0; data1 = 0; push1 = 0; pop1 = 0; clr1 = 0;

    //         rst mask     data     pu po cl  flags    cnt fu em ov un
    vt.push_back(mk(1, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 0, 0, 1, 0, 0)); // 0 reset
    vt.push_back(mk(0, 4'b1001, 4'b1111, 0, 0, 0, 4'b1001, 0, 0, 1, 0, 0)); // 1 masked write
    vt.push_back(mk(0, 4'b0000, 4'b1111, 0, 0, 0, 4'b1001, 0, 0, 1, 0, 0)); // 2 hold
    vt.push_back(mk(0, 4'b0000, 4'b0110, 0, 0, 0, 4'b1001, 0, 0, 1, 0, 0)); // 3 hold
    vt.push_back(mk(0, 4'b0000, 4'b0000, 0, 0, 0, 4'b1001, 0, 0, 1, 0, 0)); // 4 hold
    vt.push_back(mk(0, 4'b0000, 4'b0000, 1, 0, 0, 4'b1001, 1, 0, 0, 0, 0)); // 5 push 1001
    vt.push_back(mk(0, 4'b1111, 4'b0110, 0, 0, 0, 4'b0110, 1, 0, 0, 0, 0)); // 6 write 0110
    vt.push_back(mk(0, 4'b0000, 4'b0000, 1, 0, 0, 4'b0110, 2, 0, 0, 0, 0)); // 7 push 0110
    vt.push_back(mk(0, 4'b1111, 4'b0000, 0, 0, 0, 4'b0000, 2, 0, 0, 0, 0)); // 8 write 0000
    vt.push_back(mk(0, 4'b0000, 4'b0000, 0, 1, 0, 4'b0110, 1, 0, 0, 0, 0)); // 9 pop
    vt.push_back(mk(0, 4'b0000, 4'b0000, 0, 1, 0, 4'b1001, 0, 0, 1, 0, 0)); // 10 pop
    vt.push_back(mk(0, 4'b1111, 4'b0011, 0, 0, 0, 4'b0011, 0, 0, 1, 0, 0)); // 11 write 0011
    vt.push_back(mk(0, 4'b0000, 4'b0000, 0, 1, 0, 4'b0011, 0, 0, 1, 0, 1)); // 12 pop empty
    vt.push_back(mk(0, 4'b0000, 4'b0000, 0, 1, 1, 4'b0011, 0, 0, 1, 0, 1)); // 13 pop+clr
    vt.push_back(mk(0, 4'b0000, 4'b0000, 0, 0, 1, 4'b0011, 0, 0, 1, 0, 0)); // 14 clr
    vt.push_back(mk(0, 4'b0000, 4'b0000, 1, 0, 0, 4'b0011, 1, 0, 0, 0, 0)); // 15 push
    vt.push_back(mk(0, 4'b0000, 4'b0000, 1, 0, 0, 4'b0011, 2, 0, 0, 0, 0)); // 16 push
    vt.push_back(mk(0, 4'b0000, 4'b0000, 1, 0, 0, 4'b0011, 3, 0, 0, 0, 0)); // 17 push
    vt.push_back(mk(0, 4'b0000, 4'b0000, 1, 0, 0, 4'b0011, 4, 1, 0, 0, 0)); // 18 push -> full
    vt.push_back(mk(0, 4'b0100, 4'b0100, 1, 0, 0, 4'b0111, 4, 1, 0, 1, 0)); // 19 push full + write
    vt.push_back(mk(0, 4'b0000, 4'b0000, 0, 0, 1, 4'b0111, 4, 1, 0, 0, 0)); // 20 clr
    vt.push_back(mk(0, 4'b0000, 4'b0000, 1, 0, 1, 4'b0111, 4, 1, 0, 1, 0)); // 21 push+clr full
    vt.push_back(mk(0, 4'b0000, 4'b0000, 0, 0, 1, 4'b0111, 4, 1, 0, 0, 0)); // 22 clr
    vt.push_back(mk(1, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 0, 0, 1, 0, 0)); // 23 reset
    vt.push_back(mk(0, 4'b1111, 4'b1100, 0, 0, 0, 4'b1100, 0, 0, 1, 0, 0)); // 24 write 1100
    vt.push_back(mk(0, 4'b0000, 4'b0000, 1, 0, 0, 4'b1100, 1, 0, 0, 0, 0)); // 25 push 1100
    vt.push_back(mk(0, 4'b1111, 4'b0000, 0, 0, 0, 4'b0000, 1, 0, 0, 0, 0)); // 26 write 0000
    vt.push_back(mk(0, 4'b0000, 4'b0000, 1, 0, 0, 4'b0000, 2, 0, 0, 0, 0)); // 27 push 0000
    vt.push_back(mk(0, 4'b0001, 4'b0001, 1, 1, 0, 4'b0001, 2, 0, 0, 0, 0)); // 28 push+pop
    vt.push_back(mk(0, 4'b1111, 4'b1100, 0, 0, 0, 4'b1100, 2, 0, 0, 0, 0)); // 29 write 1100
    vt.push_back(mk(0, 4'b0000, 4'b0000, 1, 0, 0, 4'b1100, 3, 0, 0, 0, 0)); // 30 push 1100
    vt.push_back(mk(0, 4'b1111, 4'b0000, 0, 0, 0, 4'b0000, 3, 0, 0, 0, 0)); // 31 write 0000
    vt.push_back(mk(0, 4'b0001, 4'b0001, 0, 1, 0, 4'b1101, 2, 0, 0, 0, 0)); // 32 pop+override
    vt.push_back(mk(0, 4'b0000, 4'b0000, 1, 0, 0, 4'b1101, 3, 0, 0, 0, 0)); // 33 push 1101
    vt.push_back(mk(0, 4'b0000, 4'b0000, 0, 1, 0, 4'b1101, 2, 0, 0, 0, 0)); // 34 pop
    vt.push_back(mk(0, 4'b0000, 4'b0000, 0, 1, 0, 4'b0000, 1, 0, 0, 0, 0)); // 35 pop slot1
    vt.push_back(mk(0, 4'b0000, 4'b0000, 1, 0, 0, 4'b0000, 2, 0, 0, 0, 0)); // 36 push
    vt.push_back(mk(0, 4'b0000, 4'b0000, 1, 0, 0, 4'b0000, 3, 0, 0, 0, 0)); // 37 push
    vt.push_back(mk(1, 4'b1111, 4'b1111, 1, 0, 1, 4'b0000, 0, 0, 1, 0, 0)); // 38 reset wins
    vt.push_back(mk(0, 4'b0000, 4'b0000, 0, 1, 0, 4'b0000, 0, 0, 1, 0, 1)); // 39 pop after reset

    // Table-driven DEPTH=4 run; DEPTH=1 instance held in reset meanwhile
    for (int i = 0; i < vt.size(); i++) begin
      rst = vt[i].rst; mask = vt[i].mask; data = vt[i].data;
      push = vt[i].push; pop = vt[i].pop; clr = vt[i].clr;
      @(posedge clk); #1;
      chk("flags", i, flags, vt[i].e_flags);
      chk("count", i, {1'b0, count}, {1'b0, vt[i].e_count});
      chk("full",  i, {3'b0, full},  {3'b0, vt[i].e_full});
      chk("empty", i, {3'b0, empty}, {3'b0, vt[i].e_empty});
      chk("ovf",   i, {3'b0, ovf},   {3'b0, vt[i].e_ovf});
      chk("unf",   i, {3'b0, unf},   {3'b0, vt[i].e_unf});
    end
    rst = 0; mask = 0; push = 0; pop = 0; clr = 0;

    // DEPTH=1: full/empty alternate strictly, overflow at one entry
    chk("d1_reset_empty", 100, {3'b0, empty1}, 4'd1);
    chk("d1_reset_full",  100, {3'b0, full1},  4'd0);
    rst1 = 0; mask1 = 4'b1111; data1 = 4'b1010;
    @(posedge clk); #1;
    chk("d1_flags", 101, flags1, 4'b1010);
    mask1 = 4'b0000; push1 = 1;
    @(posedge clk); #1;
    chk("d1_push_full",  102, {3'b0, full1},  4'd1);
    chk("d1_push_empty", 102, {3'b0, empty1}, 4'd0);
    chk("d1_push_count", 102, {3'b0, count1}, 4'd1);
    mask1 = 4'b1111; data1 = 4'b0101;
    @(posedge clk); #1;
    chk("d1_ovf",        103, {3'b0, ovf1},   4'd1);
    chk("d1_ovf_count",  103, {3'b0, count1}, 4'd1);
    chk("d1_ovf_flags",  103, flags1, 4'b0101);
    push1 = 0; mask1 = 4'b0000; pop1 = 1;
    @(posedge clk); #1;
    chk("d1_pop_flags",  104, flags1, 4'b1010);
    chk("d1_pop_empty",  104, {3'b0, empty1}, 4'd1);
    chk("d1_pop_full",   104, {3'b0, full1},  4'd0);
    chk("d1_ovf_sticky", 104, {3'b0, ovf1},   4'd1);
    @(posedge clk); #1;
    chk("d1_unf",        105, {3'b0, unf1},   4'd1);
    chk("d1_unf_flags",  105, flags1, 4'b1010);
    pop1 = 0; clr1 = 1;
    @(posedge clk); #1;
    chk("d1_clr_ovf",    106, {3'b0, ovf1}, 4'd0);
    chk("d1_clr_unf",    106, {3'b0, unf1}, 4'd0);
    clr1 = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
